dtack_generator: RTL and testbench

Bus-cycle termination block for the 68k bus, sitting directly downstream of the address decoder. It consumes the decoder's active-high chip-select outputs together with the CPU strobes. Per selected region it inserts a parameterised number of wait states, or waits on a device ready/acknowledge, then drives DTACK_L. Cycles that no device acknowledges are terminated with BERR_L after a watchdog timeout.

---
 rtl/dtack_generator_if.sv | 34 +++
 rtl/dtack_generator.sv | 139 +++++++++++++
 tb/tb_dtack_generator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dtack_generator_if.sv
// 68k bus termination signals between the CPU/decoder side and dtack_generator.
// The master drives strobes and selects; the slave answers with DTACK_L/BERR_L.
interface dtack_generator_if;
  logic AS_L;
  logic UDS_L;
  logic LDS_L;
  logic OnChipRomSelect_H;
  logic OnChipRamSelect_H;
  logic DramSelect_H;
  logic IOSelect_H;
  logic CanBusSelect_H;
  logic OffBoardMemory_H;
  logic DramReady_H;
  logic ExtDtack_L;
  logic DTACK_L;
  logic BERR_L;
  logic WaitActive_H;

  modport master (
    output AS_L, UDS_L, LDS_L,
    output OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H,
    output IOSelect_H, CanBusSelect_H, OffBoardMemory_H,
    output DramReady_H, ExtDtack_L,
    input  DTACK_L, BERR_L, WaitActive_H
  );

  modport slave (
    input  AS_L, UDS_L, LDS_L,
    input  OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H,
    input  IOSelect_H, CanBusSelect_H, OffBoardMemory_H,
    input  DramReady_H, ExtDtack_L,
    output DTACK_L, BERR_L, WaitActive_H
  );
endinterface

// File: rtl/dtack_generator.sv
// 68k bus-cycle terminator: per-region wait states or device ready give DTACK_L,
// unacknowledged cycles end in BERR_L once the watchdog expires.
module dtack_generator #(
  parameter int ROM_WAIT  = 0,
  parameter int RAM_WAIT  = 1,
  parameter int IO_WAIT   = 2,
  parameter int DRAM_WAIT = 1,
  parameter int CAN_WAIT  = 4,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 8
) (
  input logic         Clk,
  input logic         Reset_H,
  dtack_generator_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [2:0] RG_ROM  = 3'd0;
  localparam logic [2:0] RG_RAM  = 3'd1;
  localparam logic [2:0] RG_IO   = 3'd2;
  localparam logic [2:0] RG_DRAM = 3'd3;
  localparam logic [2:0] RG_CAN  = 3'd4;
  localparam logic [2:0] RG_OFF  = 3'd5;
  localparam logic [2:0] RG_NONE = 3'd6;

  localparam logic [CNT_W-1:0] One    = CNT_W'(1);
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       region_q, region_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             dtackL_q, berrL_q, waitAct_q;

  logic [2:0]       regionSel;
  logic [CNT_W-1:0] regionWait;
  logic             cycleStart;
  logic             ready;

  assign cycleStart = !bus.AS_L && (!bus.UDS_L || !bus.LDS_L);

  // Fixed-priority region decode; only consulted at the start edge.
  always_comb begin
    regionSel  = RG_NONE;
    regionWait = '0;
    if (bus.OnChipRomSelect_H) begin
      regionSel  = RG_ROM;
      regionWait = CNT_W'(ROM_WAIT);
    end else if (bus.OnChipRamSelect_H) begin
      regionSel  = RG_RAM;
      regionWait = CNT_W'(RAM_WAIT);
    end else if (bus.IOSelect_H) begin
      regionSel  = RG_IO;
      regionWait = CNT_W'(IO_WAIT);
    end else if (bus.DramSelect_H) begin
      regionSel  = RG_DRAM;
      regionWait = CNT_W'(DRAM_WAIT);
    end else if (bus.CanBusSelect_H) begin
      regionSel  = RG_CAN;
      regionWait = CNT_W'(CAN_WAIT);
    end else if (bus.OffBoardMemory_H) begin
      regionSel  = RG_OFF;
    end
  end

  always_comb begin
    ready = 1'b0;
    if (waitCnt_q == '0) begin
      case (region_q)
        RG_ROM, RG_RAM, RG_IO, RG_CAN: ready = 1'b1;
        RG_DRAM:                       ready = bus.DramReady_H;
        RG_OFF:                        ready = !bus.ExtDtack_L;
        default:                       ready = 1'b0;
      endcase
    end
  end

  // Abort beats ready, and ready beats the watchdog on the same edge.
  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    waitCnt_d = waitCnt_q;
    wdog_d    = wdog_q;
    case (state_q)
      IDLE: begin
        if (cycleStart) begin
          state_d   = WAIT;
          region_d  = regionSel;
          waitCnt_d = regionWait;
          wdog_d    = '0;
        end
      end
      WAIT: begin
        if (bus.AS_L) begin
          state_d = IDLE;
        end else if (ready) begin
          state_d = ACK;
        end else if (wdog_q == WdLast) begin
          state_d = ERR;
        end else begin
          if (waitCnt_q != '0) waitCnt_d = waitCnt_q - One;
          wdog_d = wdog_q + One;
        end
      end
      default: begin
        if (bus.AS_L) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      state_q   <= IDLE;
      region_q  <= RG_NONE;
      waitCnt_q <= '0;
      wdog_q    <= '0;
      dtackL_q  <= 1'b1;
      berrL_q   <= 1'b1;
      waitAct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      waitCnt_q <= waitCnt_d;
      wdog_q    <= wdog_d;
      dtackL_q  <= (state_d != ACK);
      berrL_q   <= (state_d != ERR);
      waitAct_q <= (state_d == WAIT);
    end
  end

  assign bus.DTACK_L      = dtackL_q;
  assign bus.BERR_L       = berrL_q;
  assign bus.WaitActive_H = waitAct_q;

endmodule

// File: tb/tb_dtack_generator.sv
// Directed scoreboard bench for dtack_generator: each started cycle pushes the
// expected terminating signal and edge, popped when DTACK_L or BERR_L falls.
module tb_dtack_generator;

  typedef struct {
    string tag;
    bit    isBerr;
    int    expEdge;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_H;
  int   edgeCnt = 0;
  int   vecCnt = 0;
  int   missCnt = 0;
  int   n;
  exp_t sb[$];

  dtack_generator_if bus();

  dtack_generator dut (
    .Clk     (Clk),
    .Reset_H (Reset_H),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    assert (obs === exp) else begin
      missCnt++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // sel order: {Rom, Ram, Io, Dram, Can, Off}
  task automatic applyStimulus(input logic as, input logic ds, input logic [5:0] sel);
    bus.AS_L              = as;
    bus.UDS_L             = ds;
    bus.LDS_L             = 1'b1;
    bus.OnChipRomSelect_H = sel[5];
    bus.OnChipRamSelect_H = sel[4];
    bus.IOSelect_H        = sel[3];
    bus.DramSelect_H      = sel[2];
    bus.CanBusSelect_H    = sel[1];
    bus.OffBoardMemory_H  = sel[0];
  endtask

  task automatic startCycle(input string tag, input logic [5:0] sel, input int offset,
                            input bit isBerr, output int startEdge);
    exp_t e;
    @(negedge Clk);
    applyStimulus(1'b0, 1'b0, sel);
    startEdge = edgeCnt + 1;
    e.tag = tag;
    e.isBerr = isBerr;
    e.expEdge = startEdge + offset;
    sb.push_back(e);
    @(negedge Clk);
    checkOutput({tag, ".waitActive"}, {31'd0, bus.WaitActive_H}, 32'd1);
  endtask

  task automatic waitToEdge(input int target);
    for (int i = 0; i < 400 && edgeCnt < target; i++) @(negedge Clk);
  endtask

  task automatic waitResponse(input int budget);
    exp_t e;
    int i;
    for (i = 0; i < budget; i++) begin
      if (bus.DTACK_L === 1'b0 || bus.BERR_L === 1'b0) break;
      @(negedge Clk);
    end
    e = sb.pop_front();
    if (i == budget) begin
      checkOutput({e.tag, ".noResponse"}, 32'd0, 32'd1);
    end else begin
      checkOutput({e.tag, ".isBerr"}, {31'd0, !bus.BERR_L}, {31'd0, e.isBerr});
      checkOutput({e.tag, ".edge"}, edgeCnt, e.expEdge);
      checkOutput({e.tag, ".otherHigh"}, {31'd0, e.isBerr ? bus.DTACK_L : bus.BERR_L}, 32'd1);
    end
  endtask

  task automatic endCycle(input string tag);
    @(negedge Clk);
    applyStimulus(1'b1, 1'b1, 6'b000000);
    bus.DramReady_H = 1'b0;
    bus.ExtDtack_L  = 1'b1;
    @(negedge Clk);
    checkOutput({tag, ".dtackRel"}, {31'd0, bus.DTACK_L}, 32'd1);
    checkOutput({tag, ".berrRel"},  {31'd0, bus.BERR_L},  32'd1);
  endtask

  initial begin
    Reset_H = 1'b1;
    applyStimulus(1'b1, 1'b1, 6'b000000);
    bus.DramReady_H = 1'b0;
    bus.ExtDtack_L  = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("reset.dtack", {31'd0, bus.DTACK_L}, 32'd1);
    checkOutput("reset.berr",  {31'd0, bus.BERR_L},  32'd1);
    checkOutput("reset.wait",  {31'd0, bus.WaitActive_H}, 32'd0);
    Reset_H = 1'b0;
    repeat (2) @(negedge Clk);

    // ROM, zero wait states
    startCycle("rom", 6'b100000, 1, 1'b0, n);
    waitResponse(20);
    repeat (2) @(negedge Clk);
    checkOutput("rom.hold", {31'd0, bus.DTACK_L}, 32'd0);
    endCycle("rom");
    checkOutput("rom.idleWait", {31'd0, bus.WaitActive_H}, 32'd0);

    // RAM and IO together: RAM priority
    startCycle("ramPrio", 6'b011000, 2, 1'b0, n);
    waitResponse(20);
    endCycle("ramPrio");

    // DRAM with ready arriving at N+6
    startCycle("dramLate", 6'b000100, 6, 1'b0, n);
    waitToEdge(n + 5);
    bus.DramReady_H = 1'b1;
    waitResponse(20);
    endCycle("dramLate");

    // DRAM with ready high from the start: minimum wait applies
    bus.DramReady_H = 1'b1;
    startCycle("dramEarly", 6'b000100, 2, 1'b0, n);
    waitResponse(20);
    endCycle("dramEarly");

    // CAN; select moves to ROM after the start edge and must be ignored
    startCycle("canLatch", 6'b000010, 5, 1'b0, n);
    applyStimulus(1'b0, 1'b0, 6'b100000);
    waitResponse(20);
    endCycle("canLatch");

    // Unmapped: bus error on watchdog
    startCycle("unmapped", 6'b000000, 255, 1'b1, n);
    waitResponse(300);
    endCycle("unmapped");
    startCycle("romAfterErr", 6'b100000, 1, 1'b0, n);
    waitResponse(20);
    endCycle("romAfterErr");

    // Off-board ack on the same edge as the timeout: ack wins
    startCycle("offTie", 6'b000001, 255, 1'b0, n);
    waitToEdge(n + 254);
    bus.ExtDtack_L = 1'b0;
    waitResponse(20);
    endCycle("offTie");

    // IO cycle aborted at N+2
    startCycle("ioAbort", 6'b001000, 0, 1'b0, n);
    void'(sb.pop_back());
    waitToEdge(n + 1);
    applyStimulus(1'b1, 1'b1, 6'b000000);
    @(negedge Clk);
    checkOutput("ioAbort.wait", {31'd0, bus.WaitActive_H}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checkOutput("ioAbort.dtack", {31'd0, bus.DTACK_L}, 32'd1);
      checkOutput("ioAbort.berr",  {31'd0, bus.BERR_L},  32'd1);
    end

    // Reset during ACK, then a fresh cycle with the region seen after release
    startCycle("romPreReset", 6'b100000, 1, 1'b0, n);
    waitResponse(20);
    #2 Reset_H = 1'b1;
    #1;
    checkOutput("asyncReset.dtack", {31'd0, bus.DTACK_L}, 32'd1);
    checkOutput("asyncReset.wait",  {31'd0, bus.WaitActive_H}, 32'd0);
    applyStimulus(1'b0, 1'b0, 6'b010000);
    begin
      exp_t e;
      e.tag = "ramAfterReset";
      e.isBerr = 1'b0;
      e.expEdge = edgeCnt + 1 + 2;
      sb.push_back(e);
    end
    #1 Reset_H = 1'b0;
    @(negedge Clk);
    waitResponse(20);
    endCycle("ramAfterReset");

    checkOutput("sb.empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
